// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage between the I-cache and decode.
// Holds the fetch PC, keeps at most one I-cache read outstanding and buffers
// returned words in a DEPTH-entry FIFO that presents {pc, instr, imm} to decode.
// A flush redirects fetch; a read already in flight is completed and discarded.
// Optional feature: define IFQ_BYPASS_EN to forward a returning word straight
// to decode when the FIFO is empty (same-cycle id_valid).
module ifetch_queue #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic [WIDTH-1:0]     flush_pc,
   output logic                 icache_req,
   output logic [WIDTH-1:0]     icache_addr,
   input  logic                 icache_valid,
   input  logic [WIDTH-1:0]     icache_rdata,
   input  logic                 id_stall,
   output logic                 id_valid,
   output logic [WIDTH-1:0]     id_instr,
   output logic [WIDTH-1:0]     id_pc,
   output logic [WIDTH/2-1:0]   id_imm
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_start;
   logic [WIDTH-1:0]    r_fetch_pc;
   logic [WIDTH-1:0]    r_addr;
   logic                r_drop;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [PTR_W:0]      r_count;
   logic [WIDTH-1:0]    r_mem_pc    [DEPTH];
   logic [WIDTH-1:0]    r_mem_instr [DEPTH];

   logic                w_empty;
   logic                w_resp;
   logic                w_live;
   logic                w_push;
   logic                w_pop;
   logic [WIDTH-1:0]    w_flush_pc;

   // Redirect targets are word aligned; the two low bits are simply cleared.
   assign w_flush_pc = flush_pc & ~WIDTH'(3);
   assign w_empty    = (r_count == '0);
   // A response is "live" when it belongs to the current fetch stream.
   assign w_resp     = (r_state == S_WAIT) && icache_valid;
   assign w_live     = w_resp && !r_drop && !flush;
   assign w_pop      = !w_empty && !id_stall && !flush;

`ifdef IFQ_BYPASS_EN
   logic w_bypass;
   assign w_bypass = w_live && w_empty;
   // A bypassed word that decode accepts is never written into the FIFO.
   assign w_push   = w_live && !(w_bypass && !id_stall);
`else
   assign w_push   = w_live;
`endif

   // Fetch FSM next state: start a read only when a FIFO slot is guaranteed.
   // Starting is held off during a flush so the stale fetch_pc is never issued.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      icache_req   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!flush && (r_count < DEPTH_C)) begin
               w_state_next = S_WAIT;
               w_start      = 1'b1;
            end
         end
         S_WAIT: begin
            icache_req = 1'b1;
            if (icache_valid) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Fetch FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Fetch PC, latched request address and the drop-next-response flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_drop     <= 1'b0;
      end else begin
         if (flush) begin
            r_fetch_pc <= w_flush_pc;
         end else if (w_live) begin
            r_fetch_pc <= r_fetch_pc + WIDTH'(4);
         end
         if (w_start) begin
            r_addr <= r_fetch_pc;
         end
         if (r_state == S_WAIT) begin
            if (icache_valid) begin
               r_drop <= 1'b0;
            end else if (flush) begin
               r_drop <= 1'b1;
            end
         end
      end
   end

   // FIFO pointers and occupancy; a flush empties the queue outright.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage: capture the returned word with the address it came from.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wptr]    <= r_addr;
         r_mem_instr[r_wptr] <= icache_rdata;
      end
   end

   assign icache_addr = r_addr;

   // Decode-side view: FIFO head, zeroed when nothing valid is presented.
   always_comb begin
      id_valid = !w_empty;
      id_pc    = '0;
      id_instr = '0;
      if (!w_empty) begin
         id_pc    = r_mem_pc[r_rptr];
         id_instr = r_mem_instr[r_rptr];
      end
`ifdef IFQ_BYPASS_EN
      if (w_bypass) begin
         id_valid = 1'b1;
         id_pc    = r_addr;
         id_instr = icache_rdata;
      end
`endif
   end

   assign id_imm = id_instr[WIDTH/2-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios for ifetch_queue with a behavioural
// I-cache that answers addr ^ 32'hFFFF_0000 after a programmable wait.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_valid = 1'b0;
   logic [31:0] icache_rdata = '0;
   logic        id_stall = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [15:0] id_imm;

   int errors = 0;
   int checks = 0;
   int lat    = 0;
   int c_cnt  = 0;
   int cyc    = 0;

   logic [31:0] req_log   [$];
   logic [31:0] pop_pc    [$];
   logic [31:0] pop_instr [$];
   logic [15:0] pop_imm   [$];
   int          pop_cyc   [$];

   ifetch_queue dut (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .icache_req   (icache_req),
      .icache_addr  (icache_addr),
      .icache_valid (icache_valid),
      .icache_rdata (icache_rdata),
      .id_stall     (id_stall),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_imm       (id_imm)
   );

   always #5 clk = ~clk;

   // I-cache model: answers on the lat-th falling edge of a request.
   always @(negedge clk) begin
      if (icache_req) begin
         icache_valid = (c_cnt == lat);
         icache_rdata = icache_addr ^ 32'hFFFF_0000;
         c_cnt        = c_cnt + 1;
      end else begin
         icache_valid = 1'b0;
         c_cnt        = 0;
      end
   end

   // Transaction monitor: completed reads and words accepted by decode.
   always @(posedge clk) begin
      if (rstn) begin
         if (icache_req && icache_valid) begin
            req_log.push_back(icache_addr);
            $display("req  addr=%h data=%h drop=%0b", icache_addr, icache_rdata, dut.r_drop);
         end
         if (id_valid && !id_stall && !flush) begin
            pop_pc.push_back(id_pc);
            pop_instr.push_back(id_instr);
            pop_imm.push_back(id_imm);
            pop_cyc.push_back(cyc);
            $display("pop  pc=%h instr=%h imm=%h", id_pc, id_instr, id_imm);
         end
      end
      cyc = cyc + 1;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int latency, input logic stall);
      rstn     = 1'b0;
      flush    = 1'b0;
      flush_pc = '0;
      id_stall = stall;
      lat      = latency;
      tick();
      tick();
      req_log.delete();
      pop_pc.delete();
      pop_instr.delete();
      pop_imm.delete();
      pop_cyc.delete();
      rstn = 1'b1;
   endtask

   // Bounded wait for a request at address a with icache_valid equal to v.
   task automatic wait_req(input logic [31:0] a, input logic v, input string nm);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         tick();
         if (icache_req && icache_addr == a && icache_valid == v) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s: timeout waiting for req addr=%h valid=%0b (got addr=%h req=%0b)",
                  nm, a, v, icache_addr, icache_req);
      end
   endtask

   task automatic test_reset();
      id_stall = 1'b0;
      flush    = 1'b0;
      lat      = 0;
      rstn     = 1'b0;
      tick();
      tick();
      checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", icache_req); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
      checks++; if (icache_addr !== 32'h0000_3000) begin errors++; $display("FAIL rst_addr: got %h want 00003000", icache_addr); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
      checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
      checks++; if (id_imm !== 16'h0) begin errors++; $display("FAIL rst_id_imm: got %h want 0", id_imm); end
      rstn = 1'b1;
      tick();
      checks++;
      if (icache_req !== 1'b1 || icache_addr !== 32'h0000_3000) begin
         errors++;
         $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00003000", icache_req, icache_addr);
      end
   endtask

   task automatic test_basic();
      logic [31:0] exp_pc;
      do_reset(0, 1'b0);
      tick();
      checks++; if (id_valid !== BYP) begin errors++; $display("FAIL lat_same_cycle: id_valid got %b want %b", id_valid, BYP); end
      tick();
      checks++; if (id_valid !== ~BYP) begin errors++; $display("FAIL lat_next_cycle: id_valid got %b want %b", id_valid, ~BYP); end
      repeat (12) tick();
      for (int i = 0; i < 3; i++) begin
         exp_pc = 32'h0000_3000 + 32'(4 * i);
         checks++;
         if (pop_pc.size() <= i || pop_pc[i] !== exp_pc) begin
            errors++; $display("FAIL basic_pc[%0d]: got %h want %h", i, (pop_pc.size() > i) ? pop_pc[i] : 32'hx, exp_pc);
         end
         checks++;
         if (pop_instr.size() <= i || pop_instr[i] !== (exp_pc ^ 32'hFFFF_0000)) begin
            errors++; $display("FAIL basic_instr[%0d]: got %h want %h", i, (pop_instr.size() > i) ? pop_instr[i] : 32'hx, exp_pc ^ 32'hFFFF_0000);
         end
         checks++;
         if (pop_imm.size() <= i || pop_imm[i] !== exp_pc[15:0]) begin
            errors++; $display("FAIL basic_imm[%0d]: got %h want %h", i, (pop_imm.size() > i) ? pop_imm[i] : 16'hx, exp_pc[15:0]);
         end
      end
      checks++;
      if (pop_cyc.size() < 3 || (pop_cyc[2] - pop_cyc[1]) != 2) begin
         errors++; $display("FAIL basic_rate: pop spacing got %0d want 2", (pop_cyc.size() >= 3) ? pop_cyc[2] - pop_cyc[1] : -1);
      end
   endtask

   task automatic test_stall();
      int req_seen;
      logic [31:0] exp_pc;
      do_reset(0, 1'b1);
      repeat (20) tick();
      checks++; if (req_log.size() != 4) begin errors++; $display("FAIL stall_accepted: got %0d words want 4", req_log.size()); end
      req_seen = 0;
      repeat (8) begin
         tick();
         if (icache_req) req_seen++;
      end
      checks++; if (req_seen != 0) begin errors++; $display("FAIL stall_req_idle: got %0d req cycles want 0", req_seen); end
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0000_3000) begin
         errors++; $display("FAIL stall_head: got valid=%b pc=%h want valid=1 pc=00003000", id_valid, id_pc);
      end
      id_stall = 1'b0;
      repeat (20) tick();
      for (int i = 0; i < 6; i++) begin
         exp_pc = 32'h0000_3000 + 32'(4 * i);
         checks++;
         if (pop_pc.size() <= i || pop_pc[i] !== exp_pc) begin
            errors++; $display("FAIL stall_order[%0d]: got %h want %h", i, (pop_pc.size() > i) ? pop_pc[i] : 32'hx, exp_pc);
         end
      end
   endtask

   task automatic test_flush_wait();
      do_reset(3, 1'b0);
      wait_req(32'h0000_3008, 1'b0, "fw_reach_3008");
      flush    = 1'b1;
      flush_pc = 32'h0000_4000;
      tick();
      flush = 1'b0;
      checks++;
      if (icache_req !== 1'b1 || icache_addr !== 32'h0000_3008) begin
         errors++; $display("FAIL fw_req_held: got req=%b addr=%h want req=1 addr=00003008", icache_req, icache_addr);
      end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fw_id_valid: got %b want 0", id_valid); end
      repeat (30) tick();
      checks++;
      if (req_log.size() < 4 || req_log[3] !== 32'h0000_4000) begin
         errors++; $display("FAIL fw_next_req: got %h want 00004000", (req_log.size() > 3) ? req_log[3] : 32'hx);
      end
      checks++;
      if (pop_pc.size() < 3 || pop_pc[1] !== 32'h0000_3004 || pop_pc[2] !== 32'h0000_4000) begin
         errors++; $display("FAIL fw_pops: got %h,%h want 00003004,00004000",
                            (pop_pc.size() > 1) ? pop_pc[1] : 32'hx, (pop_pc.size() > 2) ? pop_pc[2] : 32'hx);
      end
   endtask

   task automatic test_flush_pop();
      do_reset(0, 1'b1);
      wait_req(32'h0000_3008, 1'b1, "fp_reach_3008");
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL fp_pre_valid: got %b want 1", id_valid); end
      id_stall = 1'b0;
      flush    = 1'b1;
      flush_pc = 32'h0000_4000;
      tick();
      flush = 1'b0;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fp_empty: id_valid got %b want 0", id_valid); end
      checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL fp_idle: req got %b want 0", icache_req); end
      tick();
      checks++;
      if (icache_req !== 1'b1 || icache_addr !== 32'h0000_4000) begin
         errors++; $display("FAIL fp_next_req: got req=%b addr=%h want req=1 addr=00004000", icache_req, icache_addr);
      end
      repeat (10) tick();
      checks++;
      if (pop_pc.size() < 2 || pop_pc[0] !== 32'h0000_4000 || pop_pc[1] !== 32'h0000_4004) begin
         errors++; $display("FAIL fp_pops: got %h,%h want 00004000,00004004",
                            (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, (pop_pc.size() > 1) ? pop_pc[1] : 32'hx);
      end
   endtask

   task automatic test_async_reset();
      do_reset(3, 1'b1);
      wait_req(32'h0000_3004, 1'b0, "ar_reach_3004");
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", id_valid); end
      rstn = 1'b0;
      #1;
      checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", icache_req); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ar_id_valid: got %b want 0", id_valid); end
      checks++; if (icache_addr !== 32'h0000_3000) begin errors++; $display("FAIL ar_addr: got %h want 00003000", icache_addr); end
      req_log.delete();
      pop_pc.delete();
      @(negedge clk);
      #1;
      id_stall = 1'b0;
      rstn     = 1'b1;
      repeat (20) tick();
      checks++;
      if (req_log.size() < 1 || req_log[0] !== 32'h0000_3000) begin
         errors++; $display("FAIL ar_restart: got %h want 00003000", (req_log.size() > 0) ? req_log[0] : 32'hx);
      end
      checks++;
      if (pop_pc.size() < 2 || pop_pc[0] !== 32'h0000_3000 || pop_pc[1] !== 32'h0000_3004) begin
         errors++; $display("FAIL ar_pops: got %h,%h want 00003000,00003004",
                            (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, (pop_pc.size() > 1) ? pop_pc[1] : 32'hx);
      end
   endtask

   task automatic test_wrap();
      do_reset(0, 1'b0);
      tick();
      flush    = 1'b1;
      flush_pc = 32'hFFFF_FFFF;
      tick();
      flush = 1'b0;
      wait_req(32'h0000_0000, 1'b1, "wrap_reach_0");
      checks++; if (id_valid !== BYP) begin errors++; $display("FAIL wrap_bypass_valid: got %b want %b", id_valid, BYP); end
`ifdef IFQ_BYPASS_EN
      checks++;
      if (id_pc !== 32'h0 || id_instr !== 32'hFFFF_0000) begin
         errors++; $display("FAIL wrap_bypass_data: got pc=%h instr=%h want 00000000 ffff0000", id_pc, id_instr);
      end
`endif
      repeat (6) tick();
      checks++;
      if (req_log.size() < 3 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
         errors++; $display("FAIL wrap_reqs: got %h,%h want fffffffc,00000000",
                            (req_log.size() > 1) ? req_log[1] : 32'hx, (req_log.size() > 2) ? req_log[2] : 32'hx);
      end
      checks++;
      if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0) begin
         errors++; $display("FAIL wrap_pops: got %h,%h want fffffffc,00000000",
                            (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, (pop_pc.size() > 1) ? pop_pc[1] : 32'hx);
      end
      checks++;
      if (pop_imm.size() < 2 || pop_imm[0] !== 16'hFFFC || pop_imm[1] !== 16'h0000 || pop_instr[1] !== 32'hFFFF_0000) begin
         errors++; $display("FAIL wrap_data: got imm %h,%h want fffc,0000", (pop_imm.size() > 0) ? pop_imm[0] : 16'hx,
                            (pop_imm.size() > 1) ? pop_imm[1] : 16'hx);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_stall();
      test_flush_wait();
      test_flush_pop();
      test_async_reset();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
